uart_lite_slave: RTL and testbench

//  AXI4-Lite slave behind mmu's UART port (4-bit addr space); UartLite-compatible reg map.

---
 rtl/uart_lite_slave_if.sv | 32 +++
 rtl/uart_lite_slave.sv | 177 +++++++++++++++++
 tb/tb_uart_lite_slave.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_lite_slave_if.sv
// AXI4-Lite bus bundle between the mmu UART port and uart_lite_slave.
interface uart_lite_slave_if;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, arprot, rready, awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arprot, rready, awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/uart_lite_slave.sv
// UartLite-compatible AXI4-Lite register block with TX/RX byte FIFOs and a level irq.
module uart_lite_slave #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  uart_lite_slave_if.slave        axi,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    irq
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RIdle, RAck, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WAck, WResp} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic overrun_q, overrun_d, intr_en_q, intr_en_d, irq_q;

  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PtrW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic r_ack, w_ack, tx_wr, ctrl_wr, rx_rd, stat_rd, flush_tx, flush_rx;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop, overrun_set;
  logic [31:0] stat;

  // Address/data are sampled during the ack cycle, before the master may drop them.
  assign r_ack    = (r_state_q == RAck);
  assign w_ack    = (w_state_q == WAck);
  assign tx_wr    = w_ack && (axi.awaddr[3:2] == 2'd1) && axi.wstrb[0];
  assign ctrl_wr  = w_ack && (axi.awaddr[3:2] == 2'd3) && axi.wstrb[0];
  assign rx_rd    = r_ack && (axi.araddr[3:2] == 2'd0);
  assign stat_rd  = r_ack && (axi.araddr[3:2] == 2'd2);
  assign flush_tx = ctrl_wr && axi.wdata[0];
  assign flush_rx = ctrl_wr && axi.wdata[1];

  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == CntFull);
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == CntFull);
  assign tx_pop      = !tx_empty && tx_ready;
  assign tx_push     = tx_wr && (!tx_full || tx_pop);
  assign rx_pop      = rx_rd && !rx_empty;
  assign rx_push     = rx_valid && (!rx_full || rx_pop);
  assign overrun_set = rx_valid && rx_full && !rx_pop && !flush_rx;

  assign stat = {26'b0, overrun_q, intr_en_q, tx_full, tx_empty, rx_full, !rx_empty};

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: if (axi.arvalid) r_state_d = RAck;
      RAck: begin
        r_state_d = RData;
        case (axi.araddr[3:2])
          2'd0:    rdata_d = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rd_ptr_q]};
          2'd2:    rdata_d = stat;
          default: rdata_d = 32'b0;
        endcase
      end
      RData: if (axi.rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle: if (axi.awvalid && axi.wvalid) w_state_d = WAck;
      WAck:  w_state_d = WResp;
      WResp: if (axi.bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (flush_tx) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_cnt_d    = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PtrW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PtrW'(1);
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CntW'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CntW'(1);
    end
  end

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    if (flush_rx) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_cnt_d    = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PtrW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PtrW'(1);
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CntW'(1);
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CntW'(1);
    end
  end

  // A new overrun in the same cycle as a STAT read keeps the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set)  overrun_d = 1'b1;
    else if (stat_rd) overrun_d = 1'b0;
    intr_en_d = ctrl_wr ? axi.wdata[4] : intr_en_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q   <= RIdle;
      w_state_q   <= WIdle;
      rdata_q     <= '0;
      overrun_q   <= 1'b0;
      intr_en_q   <= 1'b0;
      irq_q       <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      r_state_q   <= r_state_d;
      w_state_q   <= w_state_d;
      rdata_q     <= rdata_d;
      overrun_q   <= overrun_d;
      intr_en_q   <= intr_en_d;
      irq_q       <= intr_en_q && (!rx_empty || tx_empty);
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !flush_tx) tx_mem[tx_wr_ptr_q] <= axi.wdata[7:0];
    if (rx_push && !flush_rx) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

  assign axi.arready = r_ack;
  assign axi.rvalid  = (r_state_q == RData);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;
  assign axi.awready = w_ack;
  assign axi.wready  = w_ack;
  assign axi.bvalid  = (w_state_q == WResp);
  assign axi.bresp   = 2'b00;
  assign tx_data     = tx_mem[tx_rd_ptr_q];
  assign tx_valid    = !tx_empty;
  assign irq         = irq_q;

  logic unused_bus;
  assign unused_bus = ^{axi.arprot, axi.awprot, axi.araddr[1:0], axi.awaddr[1:0],
                        axi.wstrb[3:1], axi.wdata[31:8]};
endmodule

// File: tb/tb_uart_lite_slave.sv
// Scoreboard bench for uart_lite_slave: queued expected TX/RX bytes, per-feature test tasks.
module tb_uart_lite_slave;
  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       irq;

  uart_lite_slave_if axi_bus ();

  uart_lite_slave #(.FIFO_DEPTH(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .axi      (axi_bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       snap_tx_valid;
  logic [7:0] snap_tx_data;
  logic       snap_irq;

  // Every byte the transmitter accepts must be the next one the bench queued.
  always @(negedge clk) begin
    if (rstn && tx_valid && tx_ready) begin
      logic [7:0] exp_b;
      tests_run++;
      if (tx_q.size() == 0) begin
        tests_failed++;
        $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
      end else begin
        exp_b = tx_q.pop_front();
        if (tx_data !== exp_b) begin
          tests_failed++;
          $display("FAIL tx_byte: got %h expected %h", tx_data, exp_b);
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    axi_bus.awaddr = a; axi_bus.wdata = d; axi_bus.wstrb = s;
    axi_bus.awvalid = 1'b1; axi_bus.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(axi_bus.awready && axi_bus.wready) && n < 20) begin @(negedge clk); n++; end
    if (!(axi_bus.awready && axi_bus.wready)) begin
      tests_run++; tests_failed++;
      $display("FAIL write_ack_timeout: addr %h got no awready/wready, expected within 20", a);
    end
    @(posedge clk); #1;
    snap_tx_valid = tx_valid; snap_tx_data = tx_data; snap_irq = irq;
    axi_bus.awvalid = 1'b0; axi_bus.wvalid = 1'b0; axi_bus.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_bus.bvalid && n < 20) begin @(negedge clk); n++; end
    if (!axi_bus.bvalid || axi_bus.bresp !== 2'b00) begin
      tests_run++; tests_failed++;
      $display("FAIL write_resp: bvalid %b bresp %b, expected 1 and 00", axi_bus.bvalid,
               axi_bus.bresp);
    end
    @(posedge clk); #1;
    axi_bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    axi_bus.araddr = a; axi_bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_bus.arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    axi_bus.arvalid = 1'b0; axi_bus.rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_bus.rvalid && n < 20) begin @(negedge clk); n++; end
    if (axi_bus.rvalid && axi_bus.rresp === 2'b00) d = axi_bus.rdata;
    else d = 'x;
    @(posedge clk); #1;
    axi_bus.rready = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b, input bit track);
    rx_data = b; rx_valid = 1'b1;
    if (track && rx_q.size() < 16) rx_q.push_back(b);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    axi_bus.araddr = '0; axi_bus.arvalid = 0; axi_bus.arprot = '0; axi_bus.rready = 0;
    axi_bus.awaddr = '0; axi_bus.awvalid = 0; axi_bus.awprot = '0; axi_bus.wdata = '0;
    axi_bus.wstrb = '0; axi_bus.wvalid = 0; axi_bus.bready = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0; rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({axi_bus.arready, axi_bus.rvalid, axi_bus.awready, axi_bus.wready, axi_bus.bvalid,
         tx_valid, irq} !== 7'b0 || axi_bus.rdata !== 32'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ar%b r%b aw%b w%b b%b tx%b irq%b rdata %h, expected all 0",
               axi_bus.arready, axi_bus.rvalid, axi_bus.awready, axi_bus.wready, axi_bus.bvalid,
               tx_valid, irq, axi_bus.rdata);
    end
    rstn = 1;
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h04) begin tests_failed++; $display("FAIL reset_stat: got %h expected 04", d); end
    axi_read(4'h0, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL rx_empty_read: got %h expected 0", d); end
    axi_read(4'hC, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL ctrl_read: got %h expected 0", d); end
  endtask

  task automatic test_tx_write();
    tx_ready = 1;
    tx_q.push_back(8'h41);
    axi_write(4'h4, 32'h41, 4'b0001);
    tests_run++;
    if (snap_tx_valid !== 1'b1 || snap_tx_data !== 8'h41) begin
      tests_failed++;
      $display("FAIL tx_after_ack: got valid %b data %h expected 1 41", snap_tx_valid, snap_tx_data);
    end
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_drained: got %b expected 0", tx_valid); end
    axi_write(4'h4, 32'h99, 4'b1110);
    tests_run++;
    if (snap_tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_strobe_off: got tx_valid %b expected 0", snap_tx_valid);
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d;
    tx_ready = 0;
    axi_write(4'h4, 32'h55, 4'b0001);
    tx_q.push_back(8'h55);
    for (int i = 0; i < 17; i++) push_rx(8'(i), 1'b1);
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h23) begin tests_failed++; $display("FAIL stat_overrun: got %h expected 23", d); end
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h03) begin tests_failed++; $display("FAIL stat_overrun_clr: got %h expected 03", d); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_b;
      axi_read(4'h0, d);
      exp_b = rx_q.pop_front();
      tests_run++;
      if (d !== {24'b0, exp_b}) begin
        tests_failed++;
        $display("FAIL rx_byte_%0d: got %h expected %h", i, d, exp_b);
      end
    end
    axi_read(4'h0, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL rx_after_drain: got %h expected 0", d); end
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h00) begin tests_failed++; $display("FAIL stat_tx_held: got %h expected 00", d); end
    tx_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_release: got %b expected 0", tx_valid); end
  endtask

  task automatic test_write_stall();
    int seen, n, lost;
    axi_bus.awaddr = 4'h4; axi_bus.wdata = 32'h77; axi_bus.wstrb = 4'b0001;
    axi_bus.awvalid = 1; axi_bus.wvalid = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (axi_bus.awready || axi_bus.wready) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL aw_alone: got %0d ready cycles expected 0", seen); end
    @(posedge clk); #1;
    axi_bus.wvalid = 1;
    tx_q.push_back(8'h77);
    n = 1;
    @(negedge clk);
    while (!(axi_bus.awready && axi_bus.wready) && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    if (n != 2) begin tests_failed++; $display("FAIL aw_w_ack_latency: got %0d expected 2", n); end
    @(posedge clk); #1;
    axi_bus.awvalid = 0; axi_bus.wvalid = 0;
    lost = 0;
    repeat (4) begin @(negedge clk); if (!axi_bus.bvalid) lost++; end
    tests_run++;
    if (lost != 0) begin tests_failed++; $display("FAIL bvalid_hold: got %0d low cycles expected 0", lost); end
    @(posedge clk); #1;
    axi_bus.bready = 1;
    @(posedge clk); #1;
    axi_bus.bready = 0;
    @(negedge clk);
    tests_run++;
    if (axi_bus.bvalid !== 1'b0) begin tests_failed++; $display("FAIL bvalid_clear: got %b expected 0", axi_bus.bvalid); end
  endtask

  task automatic test_ctrl_flush();
    logic [31:0] d;
    tx_ready = 0;
    axi_write(4'h4, 32'hA1, 4'b0001);
    axi_write(4'h4, 32'hA2, 4'b0001);
    for (int i = 0; i < 3; i++) push_rx(8'hB0 + 8'(i), 1'b0);
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h01) begin tests_failed++; $display("FAIL stat_pre_flush: got %h expected 01", d); end
    axi_write(4'hC, 32'h13, 4'b0001);
    tests_run++;
    if (snap_irq !== 1'b0 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_timing: got ack %b next %b expected 0 1", snap_irq, irq);
    end
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h14) begin tests_failed++; $display("FAIL stat_flush: got %h expected 14", d); end
    axi_write(4'hC, 32'h00, 4'b0000);
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h14) begin tests_failed++; $display("FAIL ctrl_strobe_off: got %h expected 14", d); end
    axi_write(4'hC, 32'h00, 4'b0001);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_disable: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    tx_ready = 1;
    push_rx(8'h5A, 1'b1);
    tx_q.push_back(8'hC3);
    fork
      axi_read(4'h0, d);
      axi_write(4'h4, 32'hC3, 4'b0001);
    join
    tests_run++;
    if (d !== {24'b0, rx_q.pop_front()}) begin
      tests_failed++;
      $display("FAIL concurrent_read: got %h expected 5a", d);
    end
    repeat (2) @(posedge clk);
    #1;
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h04) begin tests_failed++; $display("FAIL stat_idle: got %h expected 04", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n, stray;
    tx_ready = 0;
    axi_write(4'h4, 32'h11, 4'b0001);
    push_rx(8'h22, 1'b0);
    axi_bus.araddr = 4'h8; axi_bus.arvalid = 1; axi_bus.rready = 0;
    n = 0;
    @(negedge clk);
    while (!axi_bus.rvalid && n < 20) begin
      @(negedge clk); n++;
      if (axi_bus.arready) begin @(posedge clk); #1; axi_bus.arvalid = 0; end
    end
    tests_run++;
    if (axi_bus.rvalid !== 1'b1) begin tests_failed++; $display("FAIL rvalid_before_rst: got %b expected 1", axi_bus.rvalid); end
    axi_bus.arvalid = 0;
    rstn = 0;
    #1;
    tests_run++;
    if (axi_bus.rvalid !== 1'b0 || tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got rvalid %b tx_valid %b expected 0 0", axi_bus.rvalid, tx_valid);
    end
    @(posedge clk); #1;
    rstn = 1;
    stray = 0;
    repeat (3) begin @(negedge clk); if (axi_bus.rvalid || axi_bus.bvalid) stray++; end
    tests_run++;
    if (stray != 0) begin tests_failed++; $display("FAIL post_reset_resp: got %0d expected 0", stray); end
    @(posedge clk); #1;
    axi_read(4'h8, d);
    tests_run++;
    if (d !== 32'h04) begin tests_failed++; $display("FAIL stat_after_rst: got %h expected 04", d); end
  endtask

  initial begin
    test_reset();
    test_tx_write();
    test_rx_overrun();
    test_write_stall();
    test_ctrl_flush();
    test_back_to_back();
    test_reset_mid();
    tests_run++;
    if (tx_q.size() != 0 || rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got tx %0d rx %0d left expected 0 0", tx_q.size(), rx_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
